// File: rtl/skywave_rstseq_if.sv
// Skywave-A reset sequencer bus: lock/request inputs and
// per-domain reset, ready and cause outputs.
interface skywave_rstseq_if #(
  parameter int N_DOMAINS = 4
);
  logic                 pll_locked_i;
  logic                 swrst_req_i;
  logic [N_DOMAINS-1:0] domain_rst_o;
  logic                 ready_o;
  logic [1:0]           cause_o;

  modport master (
    output pll_locked_i,
    output swrst_req_i,
    input  domain_rst_o,
    input  ready_o,
    input  cause_o
  );

  modport slave (
    input  pll_locked_i,
    input  swrst_req_i,
    output domain_rst_o,
    output ready_o,
    output cause_o
  );
endinterface

// File: rtl/skywave_rstseq.sv
// Skywave-A reset sequencer: qualified PLL lock, staged release.
// Optional sticky cause register: SKYWAVE_RSTSEQ_CAUSE_EN.
module skywave_rstseq #(
  parameter int N_DOMAINS    = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int LOCK_CYCLES  = 256,
  parameter int STAGE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  skywave_rstseq_if.slave  bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int SW = $clog2(STAGE_CYCLES + 1);
  localparam int DW = $clog2(N_DOMAINS + 1);

  typedef enum logic [1:0] {
    HOLD,
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [LW-1:0]        lock_q, lock_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [DW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic                 ready_q, ready_d;
  logic                 live;
  logic                 abort;

`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;
`endif

  assign live  = (state_q == RELEASE) || (state_q == RUN);
  assign abort = live &&
                 (!bus.pll_locked_i || bus.swrst_req_i);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lock_d  = lock_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
    cause_d = cause_q;
`endif
    unique case (state_q)
      HOLD: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (!bus.pll_locked_i) begin
          lock_d = '0;
        end else if (lock_q == LW'(LOCK_CYCLES - 1)) begin
          state_d = RELEASE;
          lock_d  = '0;
          stage_d = '0;
          idx_d   = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      RELEASE: begin
        if (stage_q == SW'(STAGE_CYCLES - 1)) begin
          stage_d = '0;
          idx_d   = idx_q + 1'b1;
          for (int k = 0; k < N_DOMAINS; k++) begin
            if (DW'(k) == idx_q) rst_d[k] = 1'b0;
          end
          if (idx_q == DW'(N_DOMAINS - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      RUN: begin
      end
      default: state_d = HOLD;
    endcase
    // Lock loss outranks a software request on the same edge.
    if (abort) begin
      state_d = HOLD;
      hold_d  = '0;
      lock_d  = '0;
      stage_d = '0;
      idx_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
      cause_d = !bus.pll_locked_i ? 2'b10 : 2'b11;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= HOLD;
      hold_q  <= '0;
      lock_q  <= '0;
      stage_q <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
      cause_q <= 2'b01;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
      cause_q <= cause_d;
`endif
    end
  end

  assign bus.domain_rst_o = rst_q;
  assign bus.ready_o      = ready_q;
`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
  assign bus.cause_o      = cause_q;
`else
  assign bus.cause_o      = 2'b00;
`endif
endmodule

// File: tb/tb_skywave_rstseq.sv
// Bench for skywave_rstseq: directed + random stimulus,
// timestamp-based reference model, queued expectations.
module tb_skywave_rstseq;
  localparam int N = 3;
  localparam int H = 2;
  localparam int L = 8;
  localparam int S = 4;

`ifdef SKYWAVE_RSTSEQ_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] rst;
    logic         rdy;
    logic [1:0]   cause;
    int           edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int       m_edge  = 0;
  int       m_entry = 0;
  int       m_run   = 0;
  int       m_t0    = -1;
  logic [1:0] m_cause = 2'b00;
  bit       started = 1'b0;

  skywave_rstseq_if #(.N_DOMAINS(N)) bus ();

  skywave_rstseq #(
    .N_DOMAINS   (N),
    .HOLD_CYCLES (H),
    .LOCK_CYCLES (L),
    .STAGE_CYCLES(S)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic enter(input logic [1:0] c);
    m_entry = m_edge;
    m_t0    = -1;
    m_run   = 0;
    m_cause = CAUSE_ON ? c : 2'b00;
  endtask

  // Model works in edge timestamps: reset entry, lock run, T0.
  task automatic model_step(input bit r, input bit l, input bit s);
    exp_t e;
    int   rel;
    m_edge++;
    if (r) begin
      started = 1'b1;
      enter(2'b01);
    end else if (!started) begin
    end else if (m_t0 >= 0) begin
      if (!l) enter(2'b10);
      else if (s) enter(2'b11);
    end else if (m_edge - m_entry > H) begin
      m_run = l ? m_run + 1 : 0;
      if (m_run == L) m_t0 = m_edge;
    end
    if (started) begin
      rel = (m_t0 < 0) ? 0 : (m_edge - m_t0) / S;
      if (rel > N) rel = N;
      for (int k = 0; k < N; k++) e.rst[k] = (k >= rel);
      e.rdy     = (rel == N);
      e.cause   = m_cause;
      e.edge_no = m_edge;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle(input bit r, input bit l, input bit s);
    reset            = r;
    bus.pll_locked_i = l;
    bus.swrst_req_i  = s;
    @(posedge clk);
    model_step(r, l, s);
    #1;
  endtask

  task automatic run_n(input int n, input bit l);
    for (int i = 0; i < n; i++) cycle(1'b0, l, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] req, input int ed);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h expected %0h",
               nm, ed, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("domain_rst", 8'(bus.domain_rst_o), 8'(e.rst), e.edge_no);
      chk("ready", 8'(bus.ready_o), 8'(e.rdy), e.edge_no);
      chk("cause", 8'(bus.cause_o), 8'(e.cause), e.edge_no);
    end
  end

  initial begin
    reset            = 1'b1;
    bus.pll_locked_i = 1'b0;
    bus.swrst_req_i  = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    run_n(30, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    run_n(16, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    run_n(3, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    run_n(25, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    run_n(14, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    run_n(4, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    run_n(24, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 399) == 0,
            $urandom_range(0, 49) != 0,
            $urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
